// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, GF(2^8) arithmetic, S-boxes, round constants and
// the round transforms used by the iterative inverse cipher.
package aes_pkg;

  localparam int unsigned Nb = 4;   // columns per state
  localparam int unsigned Nr = 10;  // rounds for AES-128

  typedef enum logic [3:0] {
    StIdle, StKeyFwd, StAdd0, StInvShift, StInvSub, StKeyBack, StAdd, StInvMix, StDone
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box definition requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, t;
    p = 8'h01;
    t = a;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      p = gf_mul(p, t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  // 256-entry tables expressed through their algebraic definition (inverse + affine map).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One forward key-expansion step: round-i key to round-(i+1) key.
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte b = 4*col + row sits at bits [127-8b -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < Nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < Nb; c++) begin
      o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_keysched.sv
// Backward key-schedule step: round-i key and round index in, round-(i-1) key out.
module aes_inv_keysched import aes_pkg::*; (
  input  logic [127:0] rk_i,
  input  logic [3:0]   round_i,
  output logic [127:0] rk_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w0_prev, w1_prev, w2_prev, w3_prev;

  assign {w0, w1, w2, w3} = rk_i;
  assign w3_prev = w3 ^ w2;
  assign w2_prev = w2 ^ w1;
  assign w1_prev = w1 ^ w0;
  assign w0_prev = w0 ^ sub_word(rot_word(w3_prev)) ^ {rcon(round_i), 24'h000000};
  assign rk_o    = {w0_prev, w1_prev, w2_prev, w3_prev};

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: expands to the last round key, then runs the rounds
// backwards, one transform per FSM state, with a start/done handshake.
module aes_dec import aes_pkg::*; #(
  parameter int unsigned SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] din,
  input  logic [127:0] keyin,
  output logic [127:0] dout,
  output logic         done,
  output logic         busy
);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] key_prev;
  logic [3:0]   round_q, round_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  aes_inv_keysched u_inv_keysched (
    .rk_i    (key_q),
    .round_i (round_q),
    .rk_o    (key_prev)
  );

  // Next-state logic: one round operation per state.
  always_comb begin
    logic [3:0] idx;
    logic [6:0] pos;
    logic [4:0] cnt_nxt;
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    idx     = 4'd0;
    pos     = 7'd0;
    cnt_nxt = 5'd0;
    case (fsm_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = din;
          key_d   = keyin;
          round_d = 4'd0;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
          fsm_d   = StKeyFwd;
        end
      end
      StKeyFwd: begin
        key_d   = key_fwd(key_q, rcon(round_q + 4'd1));
        round_d = round_q + 4'd1;
        if (round_q == 4'(Nr - 1)) fsm_d = StAdd0;
      end
      StAdd0: begin
        state_d = state_q ^ key_q;
        round_d = 4'(Nr);
        fsm_d   = StInvShift;
      end
      StInvShift: begin
        state_d = inv_shift_rows(state_q);
        fsm_d   = StInvSub;
      end
      StInvSub: begin
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
          idx = cnt_q + 4'(l);
          pos = {~idx, 3'b000};  // LSB of byte idx: 8*(15-idx)
          state_d[pos +: 8] = inv_sbox(state_q[pos +: 8]);
        end
        cnt_nxt = {1'b0, cnt_q} + 5'(SBOX_LANES);
        cnt_d   = cnt_nxt[3:0];  // wraps to 0 on the final pass
        if (cnt_nxt[4]) fsm_d = StKeyBack;
      end
      StKeyBack: begin
        key_d = key_prev;
        fsm_d = StAdd;
      end
      StAdd: begin
        state_d = state_q ^ key_q;
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) begin
          done_d = 1'b1;
          fsm_d  = StDone;
        end else begin
          fsm_d = StInvMix;
        end
      end
      StInvMix: begin
        state_d = inv_mix_cols(state_q);
        fsm_d   = StInvShift;
      end
      default: begin
        fsm_d   = StIdle;
        round_d = 4'd0;
        done_d  = 1'b0;
      end
    endcase
    busy_d = (fsm_d != StIdle) && (fsm_d != StDone);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      round_q <= 4'd0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign dout = state_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_aes_dec.sv
// Scoreboard bench for aes_dec: drivers push expected plaintext and latency, monitors pop
// on each rising edge of done.
module tb_aes_dec;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, start1 = 1'b0;
  logic [127:0] din = '0, keyin = '0, din1 = '0, keyin1 = '0;
  logic [127:0] dout, dout1;
  logic         done, busy, done1, busy1;
  logic [127:0] ks_in = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  logic [127:0] ks_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  aes_dec #(.SBOX_LANES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .keyin(keyin),
    .dout(dout), .done(done), .busy(busy)
  );

  aes_dec #(.SBOX_LANES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .keyin(keyin1),
    .dout(dout1), .done(done1), .busy(busy1)
  );

  aes_inv_keysched u_ks (
    .rk_i(ks_in), .round_i(4'd10), .rk_o(ks_out)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 16-lane instance.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut unexpected done: dout=%h expected no completion", dout);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("dut plaintext", dout, e.pt);
          chk("dut latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      prev = done;
    end
  end

  // Monitor for the single-lane instance.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done1 && !prev) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1 unexpected done: dout=%h expected no completion", dout1);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("dut1 plaintext", dout1, e.pt);
          chk("dut1 latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      prev = done1;
    end
  end

  task automatic issue(input logic [127:0] k, input logic [127:0] c, output int acc);
    start = 1'b1;
    din   = c;
    keyin = k;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_empty(input int which, input int bound);
    for (int i = 0; i < bound; i++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) return;
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL timeout dut%0d: %0d results pending, expected 0", which,
             (which == 0 ? q0.size() : q1.size()));
    if (which == 0) q0.delete();
    else q1.delete();
  endtask

  initial begin
    int acc, acc2;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout", dout, '0);
    chk("reset done", 128'(done), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("keysched r10->r9", ks_out, 128'h549932d1f08557681093ed9cbe2c974e);

    // C.1 with busy window.
    issue(K1, C1, acc);
    q0.push_back('{P1, acc, 60});
    chk("busy after accept", 128'(busy), 128'(1));
    repeat (59) @(posedge clk);
    #1;
    chk("busy at edge 59", 128'(busy), 128'(1));
    chk("done low at edge 59", 128'(done), 128'(0));
    @(posedge clk);
    #1;
    chk("busy low at edge 60", 128'(busy), 128'(0));
    wait_empty(0, 100);

    // Appendix B vector.
    issue(KB, CB, acc);
    q0.push_back('{PB, acc, 60});
    wait_empty(0, 100);

    // All-zero key; inputs and a start pulse are disturbed mid-block.
    issue('0, CZ, acc);
    q0.push_back('{128'h0, acc, 60});
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    din   = {4{32'hdeadbeef}};
    keyin = {4{32'h12345678}};
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty(0, 100);

    // start held high: C.1 then B back-to-back.
    start = 1'b1;
    din   = C1;
    keyin = K1;
    @(posedge clk);
    #1;
    acc = cyc;
    q0.push_back('{P1, acc, 60});
    din   = CB;
    keyin = KB;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = done;
    end
    chk("b2b first done seen", 128'(seen), 128'(1));
    @(posedge clk);
    #1;
    acc2 = cyc;
    q0.push_back('{PB, acc2, 60});
    start = 1'b0;
    chk("b2b done drops", 128'(done), 128'(0));
    chk("b2b dout shows new din", dout, CB);
    wait_empty(0, 100);

    // Reset 30 edges into a block, then a fresh C.1.
    issue(K1, C1, acc);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort dout", dout, '0);
    chk("abort done", 128'(done), 128'(0));
    chk("abort busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(K1, C1, acc);
    q0.push_back('{P1, acc, 60});
    wait_empty(0, 100);

    // Single-lane instance on the B vector.
    start1 = 1'b1;
    din1   = CB;
    keyin1 = KB;
    @(posedge clk);
    #1;
    acc    = cyc;
    start1 = 1'b0;
    q1.push_back('{PB, acc, 210});
    wait_empty(1, 300);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_dec.md
Name: aes_dec

Overview:
- AES-128 inverse cipher (FIPS-197 InvCipher): 128-bit ciphertext plus cipher key in, plaintext out.
- Companion to the encryption core and uses the same iterative, one-operation-per-state FSM style.
- Derives the last round key internally by forward expansion, then walks the key schedule backwards round by round, so callers supply the same key as for encryption.
- Sits beside the encryptor in the crypto datapath; a start/done handshake lets a host issue back-to-back blocks.

Parameters:
- SBOX_LANES, 16, inverse S-box lookups per cycle in INV_SUB. Legal values are 1, 2, 4, 8, 16; INV_SUB takes 16/SBOX_LANES cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-low
- start  in  1  request; sampled only in IDLE or DONE
- din  in  128  ciphertext; bits [127:120] = byte 0 (row0,col0), column-major as in FIPS-197
- keyin  in  128  cipher key (round-0 key), same byte order
- dout  out  128  current state register; plaintext is valid while done=1
- done  out  1  high from completion until the cycle after the next accepted start
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; round=0; state, key, dout all zero.
  - done=0, busy=0; the byte counter clears.
- din/keyin are captured only on the edge that accepts start. start is ignored while busy.
- FSM states: IDLE, KEY_FWD, ADD0, INV_SHIFT, INV_SUB, KEY_BACK, ADD, INV_MIX, DONE.
  - IDLE/DONE + start=1: state<=din, key<=keyin, round<=0, done<=0, go to KEY_FWD.
  - KEY_FWD: one forward expansion step per cycle (RotWord, SubWord, Rcon[round+1]); round increments. After round key 10 is computed, go to ADD0.
  - ADD0: state<=state^key; round=10; go to INV_SHIFT.
  - INV_SHIFT: rotate row r right by r bytes; one cycle.
  - INV_SUB: inverse S-box on SBOX_LANES bytes per cycle, starting at byte 0. The 4-bit byte counter wraps to 0 on exit.
  - KEY_BACK: key<=prev_key(key, round), giving the round-1 key; one cycle.
  - ADD: state<=state^key; round<=round-1.
    - If the new round is 0: done<=1, go to DONE.
    - Otherwise go to INV_MIX.
  - INV_MIX: per column, matrix {0e,0b,0d,09}, GF(2^8) with polynomial 0x11b; go to INV_SHIFT.
- Latency for SBOX_LANES=16: done rises on the 60th rising edge after the edge that accepted start. Each halving of SBOX_LANES adds 10*(16/SBOX_LANES-1) edges in total.
- start held high in DONE immediately begins the next block. done drops on the acceptance edge; dout then shows the new din.
- A reset mid-operation aborts without producing output. No partial result is held.
- Undefined FSM encodings: go to IDLE, clear round and done.

Decomposition:
- Shared package aes_pkg:
  - FSM state encodings and the Rcon[1..10] table
  - sbox/inv_sbox functions (256-entry)
  - xtime and gf_mul(a, const) helpers
  - nb/nr constants
- Sub-module aes_inv_keysched (combinational), taking the round-i key and round index and returning the round-(i-1) key:
  - w[k-4] = w[k]^w[k-1] for words 3..1
  - w0_prev = w0 ^ SubWord(RotWord(w3_prev)) ^ Rcon[i]
  - Unit-testable alone.

Test Plan:
- FIPS-197 C.1: keyin=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> dout=00112233445566778899aabbccddeeff, done at edge 60, busy high edges 1..59.
- FIPS-197 B: keyin=2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 -> dout=3243f6a8885a308d313198a2e0370734. Repeat with SBOX_LANES=1 -> same result, done at edge 210.
- All-zero key, din=66e94bd4ef8a2c3b884cfa59ca342b2e -> dout=0; change din/keyin while busy -> result unchanged.
- start held high continuously over C.1 then B vectors -> done drops one cycle, both results correct back-to-back; start pulses while busy are ignored.
- Assert rst low at edge 30 of a block -> dout=0, done=0, busy=0 immediately; a fresh start then yields the correct C.1 result.
- aes_inv_keysched standalone: round-10 key 13111d7fe3944a17f307a78b4d2b30c5, i=10 -> 549932d1f08557681093ed9cbe2c974e (C.1 key schedule).
